// File: rtl/uart_rx_sum_if.sv
// uart_rx_sum_if: serial line plus received-byte outputs of uart_rx_sum
interface uart_rx_sum_if;
    logic        ser_in;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic [31:0] rx_sum;
    logic        busy;
    modport master (output ser_in, input rx_data, rx_valid, frame_err, rx_sum, busy);
    modport slave (input ser_in, output rx_data, rx_valid, frame_err, rx_sum, busy);
endinterface

// File: rtl/uart_rx_sum.sv
// uart_rx_sum: 8N1 serial receiver with byte strobe, framing-error strobe and running byte sum
module uart_rx_sum #(
    parameter int CLOCKS_PER_BIT = 4
) (
    input logic          clk,
    input logic          rst,
    uart_rx_sum_if.slave bus
);
    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    state_t        state_q;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bitn_q;
    logic [7:0]    shift_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          err_q;
    logic [31:0]   sum_q;
    logic          s;
    assign s = sync_q[1];
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= '0;
            bitn_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            sum_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], bus.ser_in};
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!s) state_q <= START;
                end
                START: if (cnt_q == HALF_M1) begin
                    cnt_q   <= '0;
                    bitn_q  <= '0;
                    state_q <= s ? IDLE : DATA;
                end
                DATA: if (cnt_q == LAST) begin
                    cnt_q           <= '0;
                    shift_q[bitn_q] <= s;
                    bitn_q          <= bitn_q + 1'b1;
                    if (bitn_q == 3'd7) state_q <= STOP;
                end
                // Leaving at the stop midpoint lets a back-to-back start edge be caught
                STOP: if (cnt_q == LAST) begin
                    valid_q <= s;
                    err_q   <= !s;
                    if (s) begin
                        data_q <= shift_q;
                        sum_q  <= sum_q + 32'(shift_q);
                    end
                    state_q <= s ? IDLE : BREAK;
                end
                BREAK: if (s) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = err_q;
    assign bus.rx_sum    = sum_q;
    assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_sum.sv
// tb_uart_rx_sum: directed frames checked against hand-computed bytes, sums and latency
module tb_uart_rx_sum;
    localparam int CPB = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_rx_sum_if bus();
    uart_rx_sum #(.CLOCKS_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_bad = 0;
    int t_start = 0;
    int t_valid = 0;
    logic prev_pulse = 1'b0;
    logic [7:0] got[$];
    logic [7:0] hello[5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.rx_valid && bus.frame_err) n_bad++;
        if ((bus.rx_valid || bus.frame_err) && prev_pulse) n_bad++;
        prev_pulse = bus.rx_valid || bus.frame_err;
        if (bus.rx_valid) begin
            n_valid++;
            got.push_back(bus.rx_data);
            t_valid = cyc;
        end
        if (bus.frame_err) n_err++;
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask
    task automatic hold(input logic b, input int n);
        bus.ser_in = b;
        repeat (n) @(negedge clk);
    endtask
    task automatic send(input logic [7:0] b, input logic stop);
        t_start = cyc;
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stop, CPB);
    endtask
    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        bus.ser_in = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_valid = 0;
        n_err = 0;
        got.delete();
    endtask
    initial begin
        bus.ser_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(bus.rx_data), 32'h0);
        check("rst_valid", 32'(bus.rx_valid), 32'h0);
        check("rst_err", 32'(bus.frame_err), 32'h0);
        check("rst_sum", bus.rx_sum, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        // single byte with latency
        reset_dut();
        send(8'h48, 1'b1);
        hold(1'b1, 6);
        check("h_count", n_valid, 1);
        check("h_data", 32'(got[0]), 32'h48);
        check("h_sum", bus.rx_sum, 32'h48);
        check("h_latency", t_valid - t_start, 41);
        check("h_busy", 32'(bus.busy), 32'h0);
        // back-to-back message
        reset_dut();
        for (int i = 0; i < 5; i++) send(hello[i], 1'b1);
        hold(1'b1, 6);
        check("hello_count", n_valid, 5);
        for (int i = 0; i < 5; i++) check($sformatf("hello_%0d", i), 32'(got[i]), 32'(hello[i]));
        check("hello_sum", bus.rx_sum, 32'h1F4);
        check("hello_err", n_err, 0);
        // one-cycle glitch
        reset_dut();
        hold(1'b0, 1);
        hold(1'b1, 2);
        check("glitch_busy_hi", 32'(bus.busy), 32'h1);
        hold(1'b1, 2);
        check("glitch_busy_lo", 32'(bus.busy), 32'h0);
        hold(1'b1, 40);
        check("glitch_valid", n_valid, 0);
        check("glitch_err", n_err, 0);
        // framing error followed by a break, then recovery
        reset_dut();
        send(8'h12, 1'b1);
        send(8'h55, 1'b0);
        hold(1'b0, 20);
        check("ferr_count", n_err, 1);
        check("ferr_sum", bus.rx_sum, 32'h12);
        check("ferr_data", 32'(bus.rx_data), 32'h12);
        check("ferr_busy", 32'(bus.busy), 32'h1);
        hold(1'b1, 8);
        send(8'h41, 1'b1);
        hold(1'b1, 6);
        check("ferr_valid", n_valid, 2);
        check("ferr_next", 32'(got[1]), 32'h41);
        check("ferr_sum2", bus.rx_sum, 32'h53);
        check("ferr_err2", n_err, 1);
        // reset in the middle of data bit 4
        reset_dut();
        send(8'h77, 1'b1);
        hold(1'b1, 6);
        check("mid_pre_sum", bus.rx_sum, 32'h77);
        n_valid = 0;
        got.delete();
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(i[0] ? 1'b0 : 1'b1, CPB);
        hold(1'b0, 2);
        rst = 1'b1;
        bus.ser_in = 1'b1;
        @(negedge clk);
        check("mid_data", 32'(bus.rx_data), 32'h0);
        check("mid_sum", bus.rx_sum, 32'h0);
        check("mid_busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        hold(1'b1, 6);
        send(8'h3C, 1'b1);
        hold(1'b1, 6);
        check("mid_count", n_valid, 1);
        check("mid_byte", 32'(got[0]), 32'h3C);
        check("mid_sum2", bus.rx_sum, 32'h3C);
        // sum wraps modulo 2^32
        reset_dut();
        force dut.sum_q = 32'hFFFF_FFF0;
        @(negedge clk);
        release dut.sum_q;
        @(negedge clk);
        check("wrap_pre", bus.rx_sum, 32'hFFFF_FFF0);
        send(8'h20, 1'b1);
        hold(1'b1, 6);
        check("wrap_sum", bus.rx_sum, 32'h0000_0010);
        check("wrap_data", 32'(bus.rx_data), 32'h20);
        check("pulse_rules", n_bad, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
